// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional add/subtract mode is enabled by defining SERIAL_SUB_ADD_MODE_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits needed to count 0..value-1; at least 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// The mode signal exists only when SERIAL_SUB_ADD_MODE_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

`ifdef SERIAL_SUB_ADD_MODE_EN
  modport master (output start, a, b, mode, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, mode, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`endif

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_ADD_MODE_EN to add a per-operation add/subtract mode.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int                CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic             br_msb;

  logic cell_b;
  logic cell_bin;
  logic cell_d;
  logic cell_bout;
  logic br_next;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic mode_q;

  // a + b + c == a - ~b - ~c, so the subtract cell adds when b and the
  // carry are inverted around it; the flop always holds the true carry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cell_b   = b_sr[0];
    cell_bin = br;
    br_next  = cell_bout;
    if (mode_q == MODE_ADD) begin
      cell_b   = ~b_sr[0];
      cell_bin = ~br;
      br_next  = ~cell_bout;
    end
  end
`else
  assign cell_b   = b_sr[0];
  assign cell_bin = br;
  assign br_next  = cell_bout;
`endif

  full_subtractor_bit u_cell (
    .a    (a_sr[0]),
    .b    (cell_b),
    .bin  (cell_bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      // NOTE: the operand/result shifters are a few flops, not a RAM, so they reset too.
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      br_msb     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q     <= MODE_SUB;
`endif
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_q <= bus.mode;
`endif
            cnt   <= '0;
            br    <= 1'b0;
            state <= RUN;
          end
        end

        RUN: begin
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // Borrow into the MSB, needed for the overflow flag.
            br_msb <= br;
            state  <= DONE;
          end
        end

        DONE: begin
          bus.diff   <= res_sr;
          bus.borrow <= br;
          bus.ovf    <= br ^ br_msb;
          bus.done   <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/timing reference model
// plus hand-computed vectors; mode cases need SERIAL_SUB_ADD_MODE_EN.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Result of one operation from plain arithmetic: {ovf, borrow/carry, diff}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic add);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cb;
    logic         ov;
    if (add) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[W-1:0];
      cb   = full[W];
      ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b};
      r    = full[W-1:0];
      cb   = (a < b);
      ov   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {ov, cb, r};
  endfunction

  logic cur_add;
`ifdef SERIAL_SUB_ADD_MODE_EN
  assign cur_add = (bus.mode == MODE_ADD);
`else
  assign cur_add = 1'b0;
`endif

  // Timing model: edges elapsed since accept; results appear WIDTH+1 edges later.
  int           m_phase;
  logic         m_busy, m_done, m_borrow, m_ovf;
  logic [W-1:0] m_diff;
  logic [W+1:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= -1;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
      m_pend   <= '0;
    end else if (m_phase < 0) begin
      m_done <= 1'b0;
      m_busy <= bus.start;
      if (bus.start) begin
        m_phase <= 0;
        m_pend  <= ref_op(bus.a, bus.b, cur_add);
      end
    end else if (m_phase == W) begin
      m_done                     <= 1'b1;
      {m_ovf, m_borrow, m_diff}  <= m_pend;
      m_phase                    <= -1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cmp busy",   bus.busy,   m_busy);
      check("cmp done",   bus.done,   m_done);
      check("cmp diff",   bus.diff,   m_diff);
      check("cmp borrow", bus.borrow, m_borrow);
      check("cmp ovf",    bus.ovf,    m_ovf);
    end
  end

  // Issue one operation and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                        output logic [W-1:0] d, output logic bo, output logic ov);
    bit got;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
    end
    check("done seen", got, 1'b1);
    d  = bus.diff;
    bo = bus.borrow;
    ov = bus.ovf;
  endtask

  task automatic pin(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ed, input logic eb, input logic eo);
    int           lat;
    logic [W-1:0] d;
    logic         bo, ov;
    run_op(a, b, lat, d, bo, ov);
    check({name, " latency"}, lat, W + 1);
    check({name, " diff"}, d, ed);
    check({name, " borrow"}, bo, eb);
    check({name, " ovf"}, ov, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int           busy_cnt, n_done, done_k, lat;
    logic [W-1:0] d;
    logic         bo, ov;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.mode  = MODE_SUB;
`endif

    // Reset state
    #12;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset diff", bus.diff, '0);
    check("reset borrow", bus.borrow, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Pin the reference model itself
    check("model 12-35", ref_op(8'h12, 8'h35, 1'b0), {1'b0, 1'b1, 8'hDD});
    check("model 80-01", ref_op(8'h80, 8'h01, 1'b0), {1'b1, 1'b0, 8'h7F});
    check("model 7F+01", ref_op(8'h7F, 8'h01, 1'b1), {1'b1, 1'b0, 8'h80});

    // Hand-computed subtract vectors
    pin("35-12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    pin("12-35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    pin("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    pin("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    pin("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // start pulses sampled at edges 3 and 9 of a running operation
    @(negedge clk);
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    n_done    = 0;
    done_k    = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        n_done++;
        done_k = k;
      end
      bus.start = (k == 2 || k == 8);
    end
    bus.start = 1'b0;
    check("pulse busy cycles", busy_cnt, 10);
    check("pulse done count", n_done, 1);
    check("pulse done cycle", done_k, W + 1);
    check("pulse diff", bus.diff, 8'h1E);

    // Reset in the middle of RUN
    @(negedge clk);
    bus.a     = 8'h12;
    bus.b     = 8'h35;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    check("abort diff", bus.diff, '0);
    check("abort borrow", bus.borrow, 1'b0);
    check("abort ovf", bus.ovf, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort no done", n_done, 0);
    pin("post-reset 80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

`ifdef SERIAL_SUB_ADD_MODE_EN
    bus.mode = MODE_ADD;
    pin("add FF+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    pin("add 7F+01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    bus.mode = MODE_SUB;
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_SUB_ADD_MODE_EN
      bus.mode = 1'($urandom);
`endif
      run_op(W'($urandom), W'($urandom), lat, d, bo, ov);
      check("random latency", lat, W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
